// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: frost32 instruction fetch stage.
// Issues one word fetch at a time over a req/ack port, queues {pc, instr} in a small
// in-order buffer for the decoder, halts after handing off a stalling instruction until
// resume, and flushes/restarts on redirect.
// Build option: define FETCH_PREFETCH_BUF_EN for a 2-entry buffer (default: 1 entry).
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   input  logic        dec_causes_stall,
   input  logic        resume,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

`ifdef FETCH_PREFETCH_BUF_EN
   localparam int unsigned Depth = 2;
`else
   localparam int unsigned Depth = 1;
`endif
   localparam int unsigned CntW = $clog2(Depth + 1);

   localparam logic [1:0] StIdle        = 2'd0;
   localparam logic [1:0] StWaitAck     = 2'd1;
   localparam logic [1:0] StWaitDiscard = 2'd2;

   localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

   logic [1:0]      state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic            req_q, req_d;
   logic [31:0]     addr_q, addr_d;
   logic            halted_q, halted_d;
   logic            valid_q;
   logic [CntW-1:0] count_q, count_d;
   logic [CntW-1:0] fill;
   logic [31:0]     buf_pc_q    [Depth];
   logic [31:0]     buf_pc_d    [Depth];
   logic [31:0]     buf_instr_q [Depth];
   logic [31:0]     buf_instr_d [Depth];

   logic xfer, push, space_ok, issue;
   logic unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign xfer = valid_q && out_ready;
   assign push = (state_q == StWaitAck) && mem_ack && !redirect;

`ifdef FETCH_PREFETCH_BUF_EN
   assign space_ok = (count_q != CntW'(Depth));
`else
   // Single holding register: refill only behind a word leaving this cycle.
   assign space_ok = (count_q == '0) || xfer;
`endif

   assign issue = (state_q == StIdle) && !halted_q && !redirect && space_ok;

   // Fetch FSM: issue, wait for ack, or wait out a request made stale by redirect.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      pc_d    = pc_q;
      case (state_q)
         StIdle: begin
            if (issue) begin
               state_d = StWaitAck;
               req_d   = 1'b1;
               addr_d  = pc_q;
               pc_d    = pc_q + 32'd4;
            end
         end
         StWaitAck: begin
            if (mem_ack) begin
               state_d = StIdle;
               req_d   = 1'b0;
            end else if (redirect) begin
               state_d = StWaitDiscard;
            end
         end
         StWaitDiscard: begin
            if (mem_ack) begin
               state_d = StIdle;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
      if (redirect) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end
   end

   // Halt flag: set by a stalling handoff, cleared by resume; redirect always clears.
   always_comb begin
      halted_d = halted_q;
      if (resume) begin
         halted_d = 1'b0;
      end
      if (xfer && dec_causes_stall) begin
         halted_d = 1'b1;
      end
      if (redirect) begin
         halted_d = 1'b0;
      end
   end

   // Buffer: entry 0 is always the head, so pops shift down and pushes fill the tail.
   always_comb begin
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      fill        = count_q;
      if (xfer) begin
         for (int i = 0; i < int'(Depth) - 1; i++) begin
            buf_pc_d[i]    = buf_pc_q[i + 1];
            buf_instr_d[i] = buf_instr_q[i + 1];
         end
         fill = count_q - CntW'(1);
      end
      count_d = fill;
      if (push) begin
         for (int i = 0; i < int'(Depth); i++) begin
            if (CntW'(i) == fill) begin
               buf_pc_d[i]    = addr_q;
               buf_instr_d[i] = mem_rdata;
            end
         end
         count_d = fill + CntW'(1);
      end
      if (redirect) begin
         count_d = '0;
      end
   end

   // Control and fetch-port state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         pc_q     <= ResetPcAligned;
         req_q    <= 1'b0;
         addr_q   <= ResetPcAligned;
         halted_q <= 1'b0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         halted_q <= halted_d;
         count_q  <= count_d;
         valid_q  <= (count_d != '0);
      end
   end

   // Buffer storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(Depth); i++) begin
            buf_pc_q[i]    <= '0;
            buf_instr_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(Depth); i++) begin
            buf_pc_q[i]    <= buf_pc_d[i];
            buf_instr_q[i] <= buf_instr_d[i];
         end
      end
   end

   assign mem_req   = req_q;
   assign mem_addr  = addr_q;
   assign out_valid = valid_q;
   assign out_pc    = buf_pc_q[0];
   assign out_instr = buf_instr_q[0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table after reset, directed multi-cycle sequences,
// then randomized traffic checked against a queue-based model of fetch order.
module tb_instr_fetch_unit;
`ifdef FETCH_PREFETCH_BUF_EN
   localparam int Depth = 2;
`else
   localparam int Depth = 1;
`endif
   localparam logic [31:0] ResetPc = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        dec_causes_stall;
   logic        resume;
   logic        redirect;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(ResetPc)) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_req          (mem_req),
      .mem_addr         (mem_addr),
      .mem_ack          (mem_ack),
      .mem_rdata        (mem_rdata),
      .out_valid        (out_valid),
      .out_instr        (out_instr),
      .out_pc           (out_pc),
      .out_ready        (out_ready),
      .dec_causes_stall (dec_causes_stall),
      .resume           (resume),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc)
   );

   typedef struct packed {
      logic        rst;
      logic        ack;
      logic        ready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic        chk_pc;
   } vec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   int          n_chk = 0;
   int          n_fail = 0;
   vec_t        vec [11];
   logic [31:0] dlv [$];
   logic [31:0] rq [$];
   int          mem_lat;
   int          req_age;
   int          ack_cnt;
   bit          tq_req_prev;

   // Random-phase model state
   ent_t        mq [$];
   logic [31:0] exp_fetch;
   logic [31:0] addr_prev;
   bit          stale, halted_m, halted_prev, req_prev, rack_prev, hs, nh;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Leaves the bench at the sample point of the first cycle with rst low.
   task automatic do_reset();
      rst = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      out_ready = 1'b0;
      dec_causes_stall = 1'b0;
      resume = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      req_age = 0;
      tq_req_prev = 1'b0;
      ack_cnt = 0;
      dlv.delete();
      rq.delete();
   endtask

   // Ends the current cycle (logging any handshake), then answers the fetch port
   // with a fixed-latency memory for the new cycle.
   task automatic tick();
      if (out_valid && out_ready) begin
         dlv.push_back(out_pc);
         chk("dlv_instr", out_instr, mem_word(out_pc));
      end
      @(posedge clk);
      #1;
      if (mem_req && !tq_req_prev) rq.push_back(mem_addr);
      tq_req_prev = mem_req;
      mem_ack = 1'b0;
      if (mem_req) begin
         if (req_age >= mem_lat) begin
            mem_ack = 1'b1;
            mem_rdata = mem_word(mem_addr);
            req_age = 0;
            ack_cnt++;
         end else begin
            req_age++;
         end
      end else begin
         req_age = 0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;

      // rst ack rdy | req addr valid pc chk_pc
      vec[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h000, 1'b1};
      vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0};
      vec[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0};
      vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h000, 1'b0};
      vec[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, 32'h104, 1'b0};
      vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 1'b0, 32'h000, 1'b0};
      vec[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h108, 1'b1, 32'h108, 1'b0};
      vec[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10C, 1'b0, 32'h000, 1'b0};
      vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h000, 1'b1};
      vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0};
      vec[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0};

      // Cycle table: zero-wait fetches, reset mid-request, stale ack after reset
      do_reset();
      for (int i = 0; i < 11; i++) begin
         chk1($sformatf("tbl%0d_req", i), mem_req, vec[i].e_req);
         chk($sformatf("tbl%0d_addr", i), mem_addr, vec[i].e_addr);
         chk1($sformatf("tbl%0d_valid", i), out_valid, vec[i].e_valid);
         if (vec[i].e_valid || vec[i].chk_pc) begin
            chk($sformatf("tbl%0d_pc", i), out_pc, vec[i].e_pc);
            chk($sformatf("tbl%0d_instr", i), out_instr,
                vec[i].e_valid ? mem_word(vec[i].e_pc) : 32'h0);
         end
         rst = vec[i].rst;
         mem_ack = vec[i].ack;
         mem_rdata = mem_word(mem_addr);
         out_ready = vec[i].ready;
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      mem_ack = 1'b0;

      // Backpressure: fetching stops with the buffer full, nothing lost on release
      do_reset();
      mem_lat = 0;
      repeat (12) tick();
      chk("bp_words_fetched", 32'(ack_cnt), 32'(Depth));
      chk1("bp_req_stopped", mem_req, 1'b0);
      chk("bp_none_delivered", 32'(dlv.size()), 32'd0);
      out_ready = 1'b1;
      k = 0;
      while (dlv.size() < 4 && k < 50) begin tick(); k++; end
      chk1("bp_drain_done", dlv.size() >= 4, 1'b1);
      if (dlv.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk($sformatf("bp_pc%0d", i), dlv[i], ResetPc + 32'(4 * i));
      end

      // Redirect while a fetch is in flight: stale data dropped, restart aligned
      do_reset();
      mem_lat = 3;
      out_ready = 1'b1;
      k = 0;
      while (!mem_req && k < 10) begin tick(); k++; end
      redirect = 1'b1;
      redirect_pc = 32'h10;
      tick();
      redirect = 1'b0;
      chk1("rd1_valid_low", out_valid, 1'b0);
      k = 0;
      while (!(mem_req && mem_addr == 32'h10) && k < 40) begin tick(); k++; end
      chk1("rd1_fetch_0x10", mem_req && mem_addr == 32'h10, 1'b1);
      redirect = 1'b1;
      redirect_pc = 32'h2002;
      tick();
      redirect = 1'b0;
      chk1("rd2_valid_low", out_valid, 1'b0);
      dlv.delete();
      rq.delete();
      k = 0;
      while (dlv.size() < 1 && k < 40) begin tick(); k++; end
      chk1("rd2_delivered", dlv.size() >= 1, 1'b1);
      if (dlv.size() >= 1) chk("rd2_first_out_pc", dlv[0], 32'h2000);
      if (rq.size() >= 1) chk("rd2_first_mem_addr", rq[0], 32'h2000);
      else chk("rd2_req_count", 32'(rq.size()), 32'd1);

      // Stalling handoff at 0x20: 0x24 still delivers, nothing more until resume
      do_reset();
      mem_lat = 0;
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h20;
      tick();
      redirect = 1'b0;
      dlv.delete();
      rq.delete();
      for (int i = 0; i < 20; i++) begin
         dec_causes_stall = out_valid && (out_pc == 32'h20);
         tick();
      end
      dec_causes_stall = 1'b0;
      chk("st_delivered_cnt", 32'(dlv.size()), 32'd2);
      chk("st_req_cnt", 32'(rq.size()), 32'd2);
      chk1("st_req_idle", mem_req, 1'b0);
      if (dlv.size() >= 2) begin
         chk("st_pc0", dlv[0], 32'h20);
         chk("st_pc1", dlv[1], 32'h24);
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      k = 0;
      while (dlv.size() < 3 && k < 20) begin tick(); k++; end
      chk1("st_resumed", dlv.size() >= 3, 1'b1);
      if (dlv.size() >= 3) chk("st_pc2", dlv[2], 32'h28);
      if (rq.size() >= 3) chk("st_req2", rq[2], 32'h28);

      // PC wrap at the top of the address space
      do_reset();
      mem_lat = 0;
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      dlv.delete();
      rq.delete();
      k = 0;
      while (dlv.size() < 2 && k < 30) begin tick(); k++; end
      chk1("wr_delivered", dlv.size() >= 2, 1'b1);
      if (dlv.size() >= 2) begin
         chk("wr_pc0", dlv[0], 32'hFFFF_FFFC);
         chk("wr_pc1", dlv[1], 32'h0000_0000);
      end
      if (rq.size() >= 2) begin
         chk("wr_req0", rq[0], 32'hFFFF_FFFC);
         chk("wr_req1", rq[1], 32'h0000_0000);
      end

      // Randomized traffic against an in-order queue model
      do_reset();
      mq.delete();
      exp_fetch = ResetPc;
      addr_prev = '0;
      stale = 1'b0;
      halted_m = 1'b0;
      halted_prev = 1'b0;
      req_prev = 1'b0;
      rack_prev = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         chk1("rnd_valid", out_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("rnd_out_pc", out_pc, mq[0].pc);
            chk("rnd_out_instr", out_instr, mq[0].ins);
         end
         chk1("rnd_occupancy", mq.size() <= Depth, 1'b1);
         if (rack_prev) chk1("rnd_one_outstanding", mem_req, 1'b0);
         if (mem_req && !req_prev) begin
            chk("rnd_fetch_addr", mem_addr, exp_fetch);
            chk1("rnd_req_while_halted", halted_prev, 1'b0);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (mem_req && req_prev && !rack_prev) chk("rnd_addr_stable", mem_addr, addr_prev);

         out_ready = ($urandom_range(0, 3) != 0);
         mem_ack = mem_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
         mem_rdata = (mem_ack && mem_req) ? mem_word(mem_addr) : $urandom;
         dec_causes_stall = ($urandom_range(0, 3) == 0);
         resume = !dec_causes_stall && ($urandom_range(0, 5) == 0);
         redirect = ($urandom_range(0, 31) == 0);
         redirect_pc = $urandom;

         hs = (mq.size() != 0) && out_ready;
         if (hs) void'(mq.pop_front());
         if (mem_ack && mem_req) begin
            if (!stale && !redirect) mq.push_back('{mem_addr, mem_word(mem_addr)});
            stale = 1'b0;
         end
         if (redirect) begin
            mq.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
            if (mem_req && !mem_ack) stale = 1'b1;
         end
         nh = halted_m;
         if (resume) nh = 1'b0;
         if (hs && dec_causes_stall) nh = 1'b1;
         if (redirect) nh = 1'b0;
         halted_prev = halted_m;
         halted_m = nh;
         req_prev = mem_req;
         rack_prev = mem_ack && mem_req;
         addr_prev = mem_addr;
         @(posedge clk);
         #1;
      end
      mem_ack = 1'b0;
      redirect = 1'b0;
      resume = 1'b0;
      dec_causes_stall = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
